// File: rtl/led_activity_driver.sv
// Activity LED driver: synchronizes an asynchronous activity net, stretches each
// accepted edge into a fixed lit period followed by an enforced dark gap, and PWM-dims the result.
module led_activity_driver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 8,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned PWM_BITS       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                event_in,
  input  logic                force_on,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led_a,
  output logic                busy
);

  localparam int unsigned CNT_MAX = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LIT,
    GAP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   evt_edge;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic [PWM_BITS-1:0]    pwm_cnt_q;
  logic                   pwm_on;
  logic                   led_d, busy_d;

  assign evt_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign pwm_on   = (&brightness) | (pwm_cnt_q < brightness);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (evt_edge) begin
          state_d = LIT;
          cnt_d   = STRETCH_LOAD;
        end
      end
      LIT: begin
        if (evt_edge) pending_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        // An edge arriving on the final gap clock is consumed directly, so pending ends clear.
        if (cnt_q == '0) begin
          pending_d = 1'b0;
          if (pending_q || evt_edge) begin
            state_d = LIT;
            cnt_d   = STRETCH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (evt_edge) pending_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase
    led_d  = ((state_d == LIT) | force_on) & pwm_on;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      pwm_cnt_q <= '0;
      led_a     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], event_in};
      hist_q    <= sync_q[SYNC_STAGES-1];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      led_a     <= led_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_led_activity_driver.sv
// Scoreboard bench for led_activity_driver: a timeline reference model predicts
// led_a/busy for every clock; a negedge monitor pops and compares.
module tb_led_activity_driver;

  localparam int SS = 2;
  localparam int ST = 8;
  localparam int GP = 4;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          event_in = 1'b0;
  logic          force_on = 1'b0;
  logic [PB-1:0] brightness = '0;
  logic          led_a;
  logic          busy;

  led_activity_driver #(
    .SYNC_STAGES   (SS),
    .STRETCH_CYCLES(ST),
    .GAP_CYCLES    (GP),
    .PWM_BITS      (PB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .event_in  (event_in),
    .force_on  (force_on),
    .brightness(brightness),
    .led_a     (led_a),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [1:0] expq[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: event samples history, lit-window timeline, saturating pending flag.
  logic [7:0] hv;
  int         k;
  int         lit_start;
  bit         active;
  bit         pend;
  bit         exp_led;
  bit         exp_busy;

  task automatic model_reset();
    hv        = '0;
    k         = 0;
    lit_start = 0;
    active    = 0;
    pend      = 0;
    exp_led   = 0;
    exp_busy  = 0;
  endtask

  task automatic model_step();
    bit e;
    bit lit;
    hv = {hv[6:0], event_in};
    e  = hv[SS] & ~hv[SS+1];
    if (!active) begin
      if (e) begin
        active    = 1;
        lit_start = k;
      end
    end else if (k - lit_start == ST + GP) begin
      if (pend || e) begin
        lit_start = k;
        pend      = 0;
      end else begin
        active = 0;
      end
    end else if (e) begin
      pend = 1;
    end
    lit      = active && ((k - lit_start) < ST);
    exp_busy = active;
    exp_led  = (lit || force_on) && ((brightness == {PB{1'b1}}) || ((k % (1 << PB)) < int'(brightness)));
    k++;
  endtask

  task automatic cycle(input logic ev, input logic frc, input logic [PB-1:0] br, input logic r);
    @(posedge clk);
    #1;
    if (!rst) model_step();
    event_in   = ev;
    force_on   = frc;
    brightness = br;
    rst        = r;
    if (r) model_reset();
    expq.push_back({exp_led, exp_busy});
  endtask

  task automatic idle(input int n, input logic frc, input logic [PB-1:0] br);
    repeat (n) cycle(1'b0, frc, br, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_checks++;
      if (led_a !== e[1]) begin
        n_fail++;
        $display("FAIL led_a at %0t: got %b expected %b", $time, led_a, e[1]);
      end
      n_checks++;
      if (busy !== e[0]) begin
        n_fail++;
        $display("FAIL busy at %0t: got %b expected %b", $time, busy, e[0]);
      end
    end
  end

  initial begin
    logic       ev_r, frc_r, rst_r;
    logic [PB-1:0] br_r;
    model_reset();
    #1;
    rst = 1'b1;

    // Reset held with activity and lamp-test high, then release with event_in still high.
    repeat (5) cycle(1'b1, 1'b1, 4'hF, 1'b1);
    repeat (30) cycle(1'b1, 1'b0, 4'hF, 1'b0);
    idle(10, 1'b0, 4'hF);

    // Single one-clock pulse.
    cycle(1'b1, 1'b0, 4'hF, 1'b0);
    idle(20, 1'b0, 4'hF);

    // Burst of five pulses spaced two clocks apart.
    repeat (5) begin
      cycle(1'b1, 1'b0, 4'hF, 1'b0);
      cycle(1'b0, 1'b0, 4'hF, 1'b0);
    end
    idle(30, 1'b0, 4'hF);

    // Second edge lands on the final gap clock.
    cycle(1'b1, 1'b0, 4'hF, 1'b0);
    idle(11, 1'b0, 4'hF);
    cycle(1'b1, 1'b0, 4'hF, 1'b0);
    idle(30, 1'b0, 4'hF);

    // PWM under lamp-test.
    idle(40, 1'b1, 4'd5);
    idle(20, 1'b1, 4'd0);
    idle(20, 1'b1, 4'hF);
    idle(5, 1'b0, 4'hF);

    // Reset mid-lit with a pending event.
    cycle(1'b1, 1'b0, 4'hF, 1'b0);
    idle(2, 1'b0, 4'hF);
    cycle(1'b1, 1'b0, 4'hF, 1'b0);
    idle(3, 1'b0, 4'hF);
    repeat (2) cycle(1'b0, 1'b0, 4'hF, 1'b1);
    idle(25, 1'b0, 4'hF);

    // Randomized activity, brightness, lamp-test and occasional reset.
    frc_r = 1'b0;
    br_r  = 4'hA;
    repeat (700) begin
      ev_r = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) br_r = PB'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) frc_r = ~frc_r;
      rst_r = ($urandom_range(0, 249) == 0);
      cycle(ev_r, frc_r, br_r, rst_r);
    end
    idle(20, 1'b0, 4'hF);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_activity_driver.md
Name: led_activity_driver

Overview:
- Sequential stage directly upstream of the decoupled indicator LED block.
- Its registered output drives that block's anode net A.
- Turns short or irregular activity pulses on a logic net into visible, brightness-controlled LED blinks.
- Applies three operations in order: synchronization, pulse stretching with an enforced dark gap, then PWM dimming.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on event_in; legal range 2..4.
- STRETCH_CYCLES, 8, clocks the LED stays lit per accepted event; must be ≥1.
- GAP_CYCLES, 4, minimum dark clocks between two lit periods; must be ≥1.
- PWM_BITS, 4, width of the brightness control and of the PWM counter.

Ports:
- clk  input  1  single system clock.
- rst  input  1  reset, asynchronous assert, active-high.
- event_in  input  1  activity signal, asynchronous to clk.
- force_on  input  1  lamp-test; level-sensitive, synchronous to clk.
- brightness  input  PWM_BITS  duty setting; sampled every clock.
- led_a  output  1  registered drive to the LED anode net A.
- busy  output  1  registered; high while state is LIT or GAP.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: led_a=0, busy=0, state=IDLE, pending=0, all counters=0, synchronizer flops=0.
- Release of rst is synchronous to clk.
- Synchronizer: event_in passes through SYNC_STAGES flops, then one extra history flop.
  - An accepted event is a rising edge at the synchronizer output (last sync flop=1, history flop=0).
  - Edge is detected 2 clocks after first high sample when SYNC_STAGES=2.
  - event_in pulses shorter than one clock period may be missed; this is permitted.
- State machine (IDLE, LIT, GAP):
  - IDLE: on accepted edge → LIT, stretch counter = STRETCH_CYCLES-1.
  - LIT: counter decrements each clock; at 0 → GAP, gap counter = GAP_CYCLES-1.
  - LIT, edges: set pending=1. They do not extend or restart LIT, so continuous activity blinks.
  - GAP: counter decrements; at 0 → LIT if pending (clear pending, reload stretch), else IDLE.
  - GAP, edges: set pending=1.
  - Same-cycle edge and GAP exit: the edge counts. Go to LIT, and pending ends 0.
  - pending saturates at 1; multiple edges during LIT/GAP produce one additional LIT period.
- PWM:
  - Free-running PWM_BITS counter pwm_cnt, wraps 2^PWM_BITS-1 → 0.
  - Runs regardless of state.
  - pwm_on = (brightness == all-ones) or (pwm_cnt < brightness).
  - Consequences: brightness=0 gives always dark; all-ones gives 100% duty (not (2^N-1)/2^N).
- Output:
  - led_a registered: led_a <= (state_next==LIT or force_on) and pwm_on.
  - Combined with the 2-clock edge detect, led_a first rises 3 clocks after event_in is first sampled high, when pwm_on.
  - force_on overrides state but not PWM gating. It does not disturb state, counters or pending.
- busy registered: busy <= (state_next != IDLE).
- Reset mid-operation: immediate return to reset values. A pending event is discarded; no blink resumes after release.
- brightness changes take effect on the next clock; no glitch filtering is required.

Test Plan:
- Reset/idle: assert rst with event_in=1, force_on=1 → led_a=0, busy=0 throughout reset; release with event_in held 1 → exactly one LIT period (level at release counts as edge since sync flops reset to 0).
- Single pulse: brightness=4'hF, one 1-clock event_in pulse → led_a high for exactly 8 clocks starting 3 clocks after sample, then busy high 4 more clocks, then IDLE.
- Burst: 5 pulses spaced 2 clocks during LIT, brightness=4'hF → exactly two 8-clock lit periods separated by exactly 4 dark clocks, then IDLE.
- Edge at GAP exit: edge whose detection coincides with last GAP clock → LIT next clock, pending=0, no third period.
- PWM: force_on=1, brightness=4'd5 → led_a high 5 of every 16 clocks, periodic; brightness=0 → never high; 4'hF → constant high.
- Reset mid-LIT: rst pulsed at stretch count 3 with pending=1 → led_a=0 asynchronously, no lit period after release with event_in=0.
